led_press_controller: RTL and testbench

Sequencing controller for the single-button / single-LED front panel. It synchronizes and debounces the raw `button` input and classifies each press as short or long. A three-mode state machine (OFF, ON, BLINK) drives `led`, so the LED behaves as a toggle with an added blink mode. It sits between the board pin and the LED driver, and replaces ad-hoc toggle logic in the panel datapath.

---
 rtl/led_press_controller.sv | 154 +++++++++++++++
 tb/tb_led_press_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_press_controller.sv
// rtl/led_press_controller.sv - single-button front panel controller: debounce, short/long press, OFF/ON/BLINK LED modes
//
// Synchronizes and debounces a raw push-button, classifies each press as
// short or long, and steps a three-mode FSM (OFF, ON, BLINK) that drives
// the panel LED.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   button      raw bouncy button level, 1 = pressed
//   led         registered LED drive, 1 = lit
//   mode        registered mode: 0 = OFF, 1 = ON, 2 = BLINK
//   long_press  registered one-cycle pulse when a long press is recognized

module led_press_controller #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 50,
  parameter int BLINK_HALF_PERIOD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  output logic       led,
  output logic [1:0] mode,
  output logic       long_press
);

  // The debounce counter only ever holds 0..DEBOUNCE_CYCLES-1: the cycle that
  // would reach DEBOUNCE_CYCLES accepts the new level and clears instead.
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int PH_W   = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(BLINK_HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2
  } mode_t;

  logic              s1, s2;
  logic              db, db_q;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              db_rise, db_fall;
  logic              long_evt, short_evt;
  mode_t             state, state_next;
  logic              phase;
  logic [PH_W-1:0]   ph_cnt;

  // Synchronizer and debouncer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      db     <= 1'b0;
      db_q   <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1   <= button;
      s2   <= s1;
      db_q <= db;
      if (s2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db     <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Hold counter: restarts at 1 on the first high cycle after a rise so that
  // it equals the number of cycles db has been high, then saturates.
  always_comb begin
    db_rise   = db & ~db_q;
    db_fall   = ~db & db_q;
    hold_next = hold_cnt;
    if (db_rise) begin
      hold_next = HOLD_W'(1);
    end else if (db && (hold_cnt != HOLD_MAX)) begin
      hold_next = hold_cnt + 1'b1;
    end
    // Long fires only on the transition into saturation, so once per press.
    long_evt  = db & (hold_cnt != HOLD_MAX) & (hold_next == HOLD_MAX);
    // A saturated counter at release means the long event already fired.
    short_evt = db_fall & (hold_cnt != HOLD_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_next;
    end
  end

  // Mode transition table.
  always_comb begin
    state_next = state;
    if (long_evt) begin
      state_next = (state == MODE_BLINK) ? MODE_ON : MODE_BLINK;
    end else if (short_evt) begin
      state_next = (state == MODE_OFF) ? MODE_ON : MODE_OFF;
    end
  end

  // Mode FSM with registered LED and long-press outputs. A mode change takes
  // priority over a blink toggle in the same cycle and reloads the phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= MODE_OFF;
      led        <= 1'b0;
      long_press <= 1'b0;
      phase      <= 1'b0;
      ph_cnt     <= '0;
    end else begin
      long_press <= long_evt;
      if (long_evt || short_evt) begin
        state  <= state_next;
        led    <= (state_next != MODE_OFF);
        phase  <= 1'b1;
        ph_cnt <= '0;
      end else begin
        case (state)
          MODE_BLINK: begin
            if (ph_cnt == PH_LAST) begin
              ph_cnt <= '0;
              phase  <= ~phase;
              led    <= ~phase;
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
            end
          end
          MODE_ON: begin
            led    <= 1'b1;
            ph_cnt <= '0;
          end
          default: begin
            led    <= 1'b0;
            ph_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_led_press_controller.sv
// tb/tb_led_press_controller.sv - self-checking bench for led_press_controller against a press-level reference model

module tb_led_press_controller;

  localparam int DB = 4;
  localparam int LP = 50;
  localparam int HP = 8;

  logic       clk;
  logic       reset;
  logic       button;
  logic       led;
  logic [1:0] mode;
  logic       long_press;

  int tests = 0;
  int fails = 0;

  led_press_controller #(
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP),
    .BLINK_HALF_PERIOD(HP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .button    (button),
    .led       (led),
    .mode      (mode),
    .long_press(long_press)
  );

  // Rising edges at 20, 40, ...; falling edges at 10, 30, ..., 110, ...
  initial clk = 1'b1;
  always #10 clk = ~clk;

  // Reference model: works in terms of edge indices and press durations.
  int   n;            // rising edges since reset
  logic m_sync0, m_sync1;
  logic m_db;
  int   m_mis;        // consecutive edges the synchronized level disagreed with db
  int   m_rise_n;     // edge at which db last rose
  bit   m_short_pend; // short event due on the next edge
  int   m_mode;
  int   m_blink_start;
  logic m_led, m_long;

  task automatic model_reset();
    n = 0; m_sync0 = 0; m_sync1 = 0; m_db = 0; m_mis = 0; m_rise_n = 0;
    m_short_pend = 0; m_mode = 0; m_blink_start = 0; m_led = 0; m_long = 0;
  endtask

  task automatic model_edge();
    logic s2_old, db_old;
    bit   ev_long, ev_short;
    s2_old = m_sync1;
    db_old = m_db;
    n++;
    // Long: db has stayed high through the LP-th edge after its rise.
    ev_long  = db_old && ((n - m_rise_n) == LP);
    ev_short = m_short_pend;
    m_short_pend = 0;
    m_sync1 = m_sync0;
    m_sync0 = button;
    if (s2_old != db_old) begin
      m_mis++;
      if (m_mis == DB) begin
        m_db  = s2_old;
        m_mis = 0;
      end
    end else begin
      m_mis = 0;
    end
    if (m_db && !db_old) m_rise_n = n;
    if (!m_db && db_old) m_short_pend = ((n - m_rise_n) < LP);
    m_long = ev_long;
    if (ev_long)       m_mode = (m_mode == 2) ? 1 : 2;
    else if (ev_short) m_mode = (m_mode == 0) ? 1 : 0;
    if ((ev_long || ev_short) && m_mode == 2) m_blink_start = n;
    m_led = (m_mode == 1) || (m_mode == 2 && (((n - m_blink_start) / HP) % 2 == 0));
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("led", {7'd0, led}, 8'(m_led));
    check("mode", {6'd0, mode}, 8'(m_mode));
    check("long_press", {7'd0, long_press}, 8'(m_long));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous reset between clock edges, released on a falling edge.
  task automatic async_reset(input int hold_edges);
    #3 reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_led", {7'd0, led}, 8'd0);
    check("async_rst_mode", {6'd0, mode}, 8'd0);
    check("async_rst_long", {7'd0, long_press}, 8'd0);
    repeat (hold_edges) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int first, pulses, ledsum, len, cls;
  logic led63, led64;

  initial begin
    button = 1'b0;
    reset  = 1'b1;
    model_reset();

    // Reset: during and immediately after release.
    #50;
    check("rst_led_during", {7'd0, led}, 8'd0);
    check("rst_mode_during", {6'd0, mode}, 8'd0);
    check("rst_long_during", {7'd0, long_press}, 8'd0);
    #60 reset = 1'b0;
    #1;
    check("rst_led_after", {7'd0, led}, 8'd0);
    check("rst_mode_after", {6'd0, mode}, 8'd0);
    check("rst_long_after", {7'd0, long_press}, 8'd0);
    repeat (5) tick();

    // Short toggle: outputs change 6 edges after the release is first sampled.
    button = 1'b1;
    repeat (20) tick();
    button = 1'b0;
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (first == 0 && mode != 2'd0) first = i;
    end
    check("short_latency", 8'(first), 8'd7);
    check("short_on_mode", {6'd0, mode}, 8'd1);
    check("short_on_led", {7'd0, led}, 8'd1);
    repeat (10) tick();
    button = 1'b1;
    repeat (20) tick();
    button = 1'b0;
    repeat (12) tick();
    check("short_off_mode", {6'd0, mode}, 8'd0);
    check("short_off_led", {7'd0, led}, 8'd0);

    // Bounce rejection.
    repeat (3) begin
      button = 1'b1;
      repeat (2) tick();
      button = 1'b0;
      repeat (2) tick();
    end
    pulses = 0;
    repeat (20) begin
      tick();
      if (long_press) pulses++;
    end
    check("bounce_mode", {6'd0, mode}, 8'd0);
    check("bounce_led", {7'd0, led}, 8'd0);
    check("bounce_pulses", 8'(pulses), 8'd0);

    // Long press to BLINK: db rises 5 edges after first sample, long 50 later.
    button = 1'b1;
    first = 0; pulses = 0; led63 = 1'b0; led64 = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (long_press) begin
        pulses++;
        if (first == 0) first = i;
      end
      if (i == 63) led63 = led;
      if (i == 64) led64 = led;
    end
    check("long_latency", 8'(first), 8'd56);
    check("long_pulses", 8'(pulses), 8'd1);
    check("long_mode", {6'd0, mode}, 8'd2);
    check("blink_first_phase_end", {7'd0, led63}, 8'd1);
    check("blink_second_phase", {7'd0, led64}, 8'd0);
    button = 1'b0;
    repeat (20) tick();
    check("long_release_mode", {6'd0, mode}, 8'd2);

    // Exit BLINK with a short press.
    button = 1'b1;
    repeat (10) tick();
    button = 1'b0;
    repeat (12) tick();
    check("blink_short_mode", {6'd0, mode}, 8'd0);
    check("blink_short_led", {7'd0, led}, 8'd0);

    // Enter BLINK again, then exit with a long press to steady ON.
    button = 1'b1;
    repeat (60) tick();
    button = 1'b0;
    repeat (12) tick();
    check("reenter_blink_mode", {6'd0, mode}, 8'd2);
    button = 1'b1;
    repeat (60) tick();
    button = 1'b0;
    repeat (12) tick();
    check("blink_long_mode", {6'd0, mode}, 8'd1);
    ledsum = 0;
    repeat (20) begin
      tick();
      ledsum += int'(led);
    end
    check("on_steady_led", 8'(ledsum), 8'd20);

    // Reset mid-BLINK with the button held; the held press restarts.
    button = 1'b1;
    repeat (70) tick();
    check("pre_reset_blink_mode", {6'd0, mode}, 8'd2);
    async_reset(3);
    first = 0; pulses = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (long_press) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("held_reset_latency", 8'(first), 8'd56);
    check("held_reset_pulses", 8'(pulses), 8'd1);
    check("held_reset_mode", {6'd0, mode}, 8'd2);
    button = 1'b0;
    repeat (15) tick();

    // Randomized segments: bounce, short and long presses, async resets.
    for (int seg = 0; seg < 80; seg++) begin
      cls = int'($urandom_range(0, 19));
      if (cls == 19) begin
        async_reset(int'($urandom_range(0, 3)));
      end else begin
        if (cls < 8)       len = int'($urandom_range(1, 3));
        else if (cls < 14) len = int'($urandom_range(5, 40));
        else               len = int'($urandom_range(45, 90));
        button = 1'($urandom_range(0, 1));
        repeat (len) tick();
      end
    end
    button = 1'b0;
    repeat (70) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
